// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, decode enums and the ID/EX register layout.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // ALUOp: fixed add (address calc), fixed sub (compare), or funct-driven
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic              alu_src;
        result_src_e       result_src;
        alu_ctrl_e         alu_ctrl;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc4;
    } idex_t;

endpackage

// File: rtl/decode_cycle_if.sv
// Decode-stage bus: fetch inputs, writeback port, hazard flush and the ID/EX outputs.
interface decode_cycle_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            FlushE;

    logic            RegWriteE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic            ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
        input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
        output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
    );

endinterface

// File: rtl/decode_cycle_reg_file.sv
// 32x32 register file: two combinational reads with write-through, one write port, x0 fixed at zero.
module reg_file
    import riscv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [4:0]      i_a1,
    input  logic [4:0]      i_a2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd
);

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];
    logic            wr_en;

    assign wr_en = i_we && (i_wa != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[i_wa] = i_wd;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass lets decode see a value being written back in the same cycle
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        if (i_a1 != 5'd0) begin
            o_rd1 = (wr_en && (i_wa == i_a1)) ? i_wd : regs_q[i_a1];
        end
        if (i_a2 != 5'd0) begin
            o_rd2 = (wr_en && (i_wa == i_a2)) ? i_wd : regs_q[i_a2];
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extension and the ID/EX register.
module decode_cycle
    import riscv_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    decode_cycle_if.slave bus
);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;

    logic             reg_write;
    logic             mem_write;
    logic             jump;
    logic             branch;
    logic             alu_src;
    result_src_e      result_src;
    imm_src_e         imm_src;
    alu_op_e          alu_op;
    alu_ctrl_e        alu_ctrl;
    logic signed [XLEN-1:0] imm_ext;

    idex_t idex_d;
    idex_t idex_q;

    function automatic logic signed [XLEN-1:0] imm_extend(input logic [XLEN-1:0] instr,
                                                          input imm_src_e    src);
        logic signed [XLEN-1:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    assign opcode   = bus.InstrD[6:0];
    assign funct3   = bus.InstrD[14:12];
    assign funct7_5 = bus.InstrD[30];
    assign rs1      = bus.InstrD[19:15];
    assign rs2      = bus.InstrD[24:20];
    assign rd       = bus.InstrD[11:7];

    reg_file u_reg_file (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_a1    (rs1),
        .i_a2    (rs2),
        .o_rd1   (rd1),
        .o_rd2   (rd2),
        .i_we    (bus.RegWriteW),
        .i_wa    (bus.RdW),
        .i_wd    (bus.ResultW)
    );

    // Main decoder: unrecognised opcodes keep the all-zero defaults (bubble)
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        result_src = RES_ALU;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        case (opcode)
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_BEQ: begin
                branch  = 1'b1;
                imm_src = IMM_B;
                alu_op  = ALUOP_SUB;
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                imm_src    = IMM_J;
                result_src = RES_PC4;
            end
            default: ;
        endcase
    end

    // ALU decoder: funct7[5] selects sub only for register-register ops, since
    // on addi that bit belongs to the immediate
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = (opcode[5] && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    assign imm_ext = imm_extend(bus.InstrD, imm_src);

    always_comb begin
        idex_d = '0;
        if (!bus.FlushE) begin
            idex_d.reg_write  = reg_write;
            idex_d.mem_write  = mem_write;
            idex_d.jump       = jump;
            idex_d.branch     = branch;
            idex_d.alu_src    = alu_src;
            idex_d.result_src = result_src;
            idex_d.alu_ctrl   = alu_ctrl;
            idex_d.rs1        = rs1;
            idex_d.rs2        = rs2;
            idex_d.rd         = rd;
            idex_d.rd1        = rd1;
            idex_d.rd2        = rd2;
            idex_d.imm        = imm_ext;
            idex_d.pc         = bus.PCD;
            idex_d.pc4        = bus.PCPlus4D;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.RegWriteE   = idex_q.reg_write;
    assign bus.MemWriteE   = idex_q.mem_write;
    assign bus.JumpE       = idex_q.jump;
    assign bus.BranchE     = idex_q.branch;
    assign bus.ALUSrcE     = idex_q.alu_src;
    assign bus.ResultSrcE  = idex_q.result_src;
    assign bus.ALUControlE = idex_q.alu_ctrl;
    assign bus.RD1E        = idex_q.rd1;
    assign bus.RD2E        = idex_q.rd2;
    assign bus.ImmExtE     = idex_q.imm;
    assign bus.PCE         = idex_q.pc;
    assign bus.PCPlus4E    = idex_q.pc4;
    assign bus.Rs1E        = idex_q.rs1;
    assign bus.Rs2E        = idex_q.rs2;
    assign bus.RdE         = idex_q.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: expectations queued as each instruction is driven, checked after the capturing edge.
module tb_decode_cycle;

    logic clk;
    logic rst_n;

    decode_cycle_if bus ();

    decode_cycle dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [9:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        bit          chk_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] pcv    = 32'h0000_1000;

    // {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
    function automatic logic [9:0] ctl(input logic rw, input logic mw, input logic j, input logic b,
                                       input logic as, input logic [1:0] rs, input logic [2:0] alu);
        return {rw, mw, j, b, as, rs, alu};
    endfunction

    function automatic exp_t mk(input string tag, input logic [9:0] c, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] im, input bit ci,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        exp_t e;
        e.tag = tag; e.ctrl = c; e.rd1 = r1; e.rd2 = r2; e.imm = im; e.chk_imm = ci;
        e.rs1 = s1; e.rs2 = s2; e.rd = d; e.pc = '0; e.pc4 = '0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic logic [9:0] obs_ctrl();
        return {bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE, bus.ALUSrcE,
                bus.ResultSrcE, bus.ALUControlE};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {22'd0, obs_ctrl()}, 32'd0);
        chk({tag, "_rd1"},  bus.RD1E, 32'd0);
        chk({tag, "_rd2"},  bus.RD2E, 32'd0);
        chk({tag, "_imm"},  bus.ImmExtE, 32'd0);
        chk({tag, "_pc"},   bus.PCE, 32'd0);
        chk({tag, "_pc4"},  bus.PCPlus4E, 32'd0);
        chk({tag, "_idx"},  {17'd0, bus.Rs1E, bus.Rs2E, bus.RdE}, 32'd0);
    endtask

    task automatic check_next();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_ctrl"}, {22'd0, obs_ctrl()}, {22'd0, e.ctrl});
        chk({e.tag, "_rd1"},  bus.RD1E, e.rd1);
        chk({e.tag, "_rd2"},  bus.RD2E, e.rd2);
        if (e.chk_imm) chk({e.tag, "_imm"}, bus.ImmExtE, e.imm);
        chk({e.tag, "_rs1"},  {27'd0, bus.Rs1E}, {27'd0, e.rs1});
        chk({e.tag, "_rs2"},  {27'd0, bus.Rs2E}, {27'd0, e.rs2});
        chk({e.tag, "_rd"},   {27'd0, bus.RdE},  {27'd0, e.rd});
        chk({e.tag, "_pc"},   bus.PCE, e.pc);
        chk({e.tag, "_pc4"},  bus.PCPlus4E, e.pc4);
    endtask

    task automatic step(input logic [31:0] instr, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic flush, input exp_t e);
        @(negedge clk);
        bus.InstrD    = instr;
        bus.PCD       = pcv;
        bus.PCPlus4D  = pcv + 32'd4;
        bus.RegWriteW = we;
        bus.RdW       = wa;
        bus.ResultW   = wd;
        bus.FlushE    = flush;
        e.pc          = flush ? 32'd0 : pcv;
        e.pc4         = flush ? 32'd0 : pcv + 32'd4;
        sb.push_back(e);
        pcv = pcv + 32'd4;
        @(posedge clk);
        #1;
        check_next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.InstrD    = '0;
        bus.PCD       = '0;
        bus.PCPlus4D  = '0;
        bus.RegWriteW = 1'b0;
        bus.RdW       = '0;
        bus.ResultW   = '0;
        bus.FlushE    = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Preload x1 = 5, x2 = 7 under bubbles
        step(32'h0000_0000, 1'b1, 5'd1, 32'd5, 1'b0, mk("bubble_w1", 10'd0, 0, 0, 0, 1'b1, 0, 0, 0));
        step(32'h0000_0000, 1'b1, 5'd2, 32'd7, 1'b0, mk("bubble_w2", 10'd0, 0, 0, 0, 1'b1, 0, 0, 0));

        step(32'h0020_81B3, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("add", ctl(1,0,0,0,0,2'b00,3'b000), 32'd5, 32'd7, 0, 1'b0, 1, 2, 3));
        step(32'h0020_81B3, 1'b1, 5'd1, 32'hDEAD_BEEF, 1'b0,
             mk("add_wthru", ctl(1,0,0,0,0,2'b00,3'b000), 32'hDEAD_BEEF, 32'd7, 0, 1'b0, 1, 2, 3));
        step(32'h0020_01B3, 1'b1, 5'd0, 32'h1234_5678, 1'b0,
             mk("add_x0", ctl(1,0,0,0,0,2'b00,3'b000), 32'd0, 32'd7, 0, 1'b0, 0, 2, 3));
        step(32'h0020_81B3, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("add_stored", ctl(1,0,0,0,0,2'b00,3'b000), 32'hDEAD_BEEF, 32'd7, 0, 1'b0, 1, 2, 3));

        step(32'hFE20_AE23, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("sw", ctl(0,1,0,0,1,2'b00,3'b000), 32'hDEAD_BEEF, 32'd7, 32'hFFFF_FFFC, 1'b1, 1, 2, 28));
        step(32'h0020_8463, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("beq", ctl(0,0,0,1,0,2'b00,3'b001), 32'hDEAD_BEEF, 32'd7, 32'd8, 1'b1, 1, 2, 8));
        step(32'h00C1_2283, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("lw", ctl(1,0,0,0,1,2'b01,3'b000), 32'd7, 32'd0, 32'd12, 1'b1, 2, 12, 5));
        step(32'h0100_00EF, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("jal", ctl(1,0,1,0,0,2'b10,3'b000), 32'd0, 32'd0, 32'd16, 1'b1, 0, 16, 1));
        step(32'hFFF0_8213, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("addi_neg", ctl(1,0,0,0,1,2'b00,3'b000), 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 31, 4));

        step(32'h4020_81B3, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("sub", ctl(1,0,0,0,0,2'b00,3'b001), 32'hDEAD_BEEF, 32'd7, 0, 1'b0, 1, 2, 3));
        step(32'h0020_F1B3, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("and", ctl(1,0,0,0,0,2'b00,3'b010), 32'hDEAD_BEEF, 32'd7, 0, 1'b0, 1, 2, 3));
        step(32'h0020_E1B3, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("or", ctl(1,0,0,0,0,2'b00,3'b011), 32'hDEAD_BEEF, 32'd7, 0, 1'b0, 1, 2, 3));
        step(32'h0020_A1B3, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("slt", ctl(1,0,0,0,0,2'b00,3'b101), 32'hDEAD_BEEF, 32'd7, 0, 1'b0, 1, 2, 3));
        step(32'h0020_A193, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("slti", ctl(1,0,0,0,1,2'b00,3'b101), 32'hDEAD_BEEF, 32'd7, 32'd2, 1'b1, 1, 2, 3));
        step(32'h0020_E193, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("ori", ctl(1,0,0,0,1,2'b00,3'b011), 32'hDEAD_BEEF, 32'd7, 32'd2, 1'b1, 1, 2, 3));
        step(32'h0020_F193, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("andi", ctl(1,0,0,0,1,2'b00,3'b010), 32'hDEAD_BEEF, 32'd7, 32'd2, 1'b1, 1, 2, 3));

        // Flush beats the decode, but the concurrent write to x5 still lands
        step(32'h0020_81B3, 1'b1, 5'd5, 32'h0000_0055, 1'b1,
             mk("flush", 10'd0, 0, 0, 0, 1'b1, 0, 0, 0));
        step(32'h0002_81B3, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("add_x5", ctl(1,0,0,0,0,2'b00,3'b000), 32'h0000_0055, 32'd0, 0, 1'b0, 5, 0, 3));
        step(32'h0000_007F, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("unknown_op", 10'd0, 32'd0, 32'd0, 0, 1'b0, 0, 0, 0));

        step(32'h0020_81B3, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("add_prerst", ctl(1,0,0,0,0,2'b00,3'b000), 32'hDEAD_BEEF, 32'd7, 0, 1'b0, 1, 2, 3));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h0020_81B3, 1'b0, 5'd0, 32'd0, 1'b0,
             mk("add_postrst", ctl(1,0,0,0,0,2'b00,3'b000), 32'd0, 32'd0, 0, 1'b0, 1, 2, 3));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second stage of the five-stage RV32I pipeline. Consumes the instruction, PC and PC+4 registered by the fetch stage, decodes control, reads the register file, and sign-extends the immediate. Results are registered into the ID/EX pipeline register for the execute stage. The block owns the 32×32 register file, whose write port is driven from writeback.

## Interface
Parameters:
- none; widths are fixed by the shared package (XLEN = 32).

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `InstrD`  in  32  instruction from the fetch stage.
- `PCD`  in  32  PC of `InstrD`.
- `PCPlus4D`  in  32  PC+4 of `InstrD`.
- `RegWriteW`  in  1  writeback write enable.
- `RdW`  in  5  writeback destination register.
- `ResultW`  in  32  writeback data.
- `FlushE`  in  1  from the hazard unit; load a bubble into ID/EX.
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE`  out  1 each  registered control.
- `ResultSrcE`  out  2  result select: 00 = ALU, 01 = memory, 10 = PC+4.
- `ALUControlE`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `RD1E`, `RD2E`  out  32  register operands.
- `ImmExtE`  out  32  sign-extended immediate.
- `PCE`, `PCPlus4E`  out  32  passed through from decode.
- `Rs1E`, `Rs2E`, `RdE`  out  5  register indices, for forwarding and hazard detection.

## Operation
- Supported opcodes:
  - R-type (0110011): add, sub, and, or, slt.
  - I-ALU (0010011): addi, andi, ori, slti.
  - lw (0000011), sw (0100011), beq (1100011), jal (1101111).
- Any other opcode decodes to all-zero control (bubble). There is no exception path.
- Main decoder produces RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp and Jump.
- ALU decoder maps ALUOp/funct3/funct7[5] to ALUControl:
  - lw/sw → add; beq → sub.
  - R-type sub only when funct7[5] = 1 and opcode[5] = 1.
- Immediate extension (ImmSrc):
  - 00 I: {20×i[31], i[31:20]}.
  - 01 S: {20×i[31], i[31:25], i[11:7]}.
  - 10 B: {19×i[31], i[31], i[7], i[30:25], i[11:8], 0}.
  - 11 J: {11×i[31], i[31], i[19:12], i[20], i[30:21], 0}.
- Register file:
  - Two combinational read ports (rs1 = InstrD[19:15], rs2 = InstrD[24:20]); one write port.
  - Write occurs at the rising edge when `RegWriteW` = 1 and `RdW` ≠ 0.
  - x0 always reads 0; writes to x0 are dropped.
  - Write-through: a same-cycle read of `RdW` (with `RegWriteW` = 1 and `RdW` ≠ 0) returns `ResultW`.
- ID/EX register:
  - Captures every E output at the rising edge.
  - `FlushE` = 1: all control outputs load 0; data/index fields load 0.
- No stall input. Upstream holds `InstrD` steady while stalling, which is safe because decode is stateless apart from the register file.

## Timing
- Latency: `InstrD` at edge N appears on the E outputs after edge N+1 (one cycle).
- Register-file write at edge N is visible to a decode read in cycle N through write-through, and thereafter from storage.
- Reset (asynchronous):
  - Every output and all 32 registers go to 0 immediately on `i_rst_n` = 0.
  - Reset asserted mid-operation discards in-flight ID/EX contents.
  - First capture after reset release is at the first rising edge with `i_rst_n` = 1.
- Simultaneous `FlushE` and a valid decode: flush wins.
- Simultaneous `FlushE` and a register-file write: the write still commits.

## Structure
- `riscv_pkg` holds:
  - opcode constants;
  - `alu_ctrl_e`, `imm_src_e`, `result_src_e` enums;
  - the ALUOp encoding;
  - XLEN.
- One sub-module, `reg_file`: 32×32, async-reset clear, x0 hardwired to zero, write-through bypass.
- Control decode, immediate extension and the ID/EX register live in `decode_cycle`.

## Test plan
- Preload x1 = 5 and x2 = 7 via the write port, then `InstrD` = 0x002081B3 (add x3,x1,x2) → next cycle: `RD1E` = 5, `RD2E` = 7, `RdE` = 3, `ALUControlE` = 000, `RegWriteE` = 1, `ALUSrcE` = 0.
- `RegWriteW` = 1, `RdW` = 1, `ResultW` = 0xDEADBEEF in the same cycle as the add → `RD1E` = 0xDEADBEEF. Repeat with `RdW` = 0 → x0 still reads 0.
- `InstrD` = 0xFE20AE23 (sw x2,-4(x1)) → `ImmExtE` = 0xFFFFFFFC, `MemWriteE` = 1, `RegWriteE` = 0, `ALUSrcE` = 1.
- `InstrD` = 0x00208463 (beq x1,x2,+8) → `ImmExtE` = 0x00000008, `BranchE` = 1, `ALUControlE` = 001.
- Valid add with `FlushE` = 1 → next cycle: all control outputs 0. Unknown opcode 0x0000007F → all control outputs 0.
- Drive `i_rst_n` low mid-stream, between edges → all outputs 0 without a clock edge, and x1 reads 0 after release.
